// File: rtl/if_id_skid.sv
// IF/ID pipeline boundary register.
// Carries {pc, inst} from fetch to decode over a valid/ready handshake.
// SKID=1: a 2-entry skid buffer with a registered in_ready, so decode stalls
//         never reach fetch through a combinational path.
// SKID=0: a single entry with a combinational in_ready.
// A synchronous flush drops every held instruction.
// inst_o carries NOP_INST whenever the stage is empty.
module if_id_skid #(
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        PC_W     = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0013,
  parameter bit                 SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              flush_i,
  output logic [1:0]        level_o
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [PC_W-1:0]     r_pc;
  logic [INST_W-1:0]   r_inst;
  logic [PC_W-1:0]     r_skid_pc;
  logic [INST_W-1:0]   r_skid_inst;

  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_out_fire;

  // in_ready comes from a flop when the skid buffer is present.
  // Without the skid buffer it is derived from the head and from decode.
  generate
    if (SKID) begin : g_skid_ready
      assign w_in_ready = r_in_ready;
    end else begin : g_pass_ready
      // The term rst_n blocks any acceptance during the reset cycle.
      assign w_in_ready = rst_n & (~r_out_valid | out_ready);
    end
  endgenerate

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign pc_o      = r_pc;
  assign inst_o    = r_inst;
  assign level_o   = r_state;

  // Occupancy FSM with registered head, skid entry and handshake outputs.
  // Reset takes priority over flush, and flush takes priority over any fire.
  // NOTE: every state element here uses <= so that all flops sample the
  //       values from before the edge; mixing in = would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the skid data registers are left unreset. They are only read
      //       after a write in FULL, so resetting them would add routing and gain nothing.
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_pc        <= '0;
      r_inst      <= NOP_INST;
    end else if (flush_i) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_inst      <= NOP_INST;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_pc        <= pc_i;
            r_inst      <= inst_i;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            // The head drains and refills in the same cycle.
            r_pc   <= pc_i;
            r_inst <= inst_i;
          end else if (w_in_fire) begin
            // Decode is stalled, so the new instruction goes into the skid entry.
            // This case cannot occur when SKID=0, because in_ready then requires out_ready.
            r_state     <= ST_FULL;
            r_in_ready  <= 1'b0;
            r_skid_pc   <= pc_i;
            r_skid_inst <= inst_i;
          end else if (w_out_fire) begin
            // pc_o keeps the last PC; only the instruction goes back to NOP.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_inst      <= NOP_INST;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
            r_pc       <= r_skid_pc;
            r_inst     <= r_skid_inst;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_inst      <= NOP_INST;
        end
      endcase
    end
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF/ID pipeline boundary register with a valid/ready handshake, an optional 2-entry skid buffer, and a synchronous flush.
- Sits between the fetch stage (PC plus fetched instruction) and the decode stage.
- Lets decode stall without a combinational ready path back into fetch.
- Lets a taken branch or jump kill in-flight instructions.
- Whenever the output is empty, the stage presents a NOP so decode always sees a legal encoding.

Parameters:
- INST_W, 32, instruction width in bits.
- PC_W, 32, program counter width in bits.
- NOP_INST, 32'h00000013 (addi x0,x0,0), encoding driven on inst_o when empty; must fit in INST_W.
- SKID, 1:
  - 1 = 2-entry skid buffer, in_ready registered.
  - 0 = single entry, in_ready combinational.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  fetch offers pc_i/inst_i this cycle.
- in_ready  output  1  stage accepts the offer this cycle.
- pc_i  input  PC_W  PC of the offered instruction.
- inst_i  input  INST_W  offered instruction.
- out_valid  output  1  pc_o/inst_o hold a live instruction.
- out_ready  input  1  decode consumes the output this cycle.
- pc_o  output  PC_W  PC of the head instruction.
- inst_o  output  INST_W  head instruction; NOP_INST when out_valid=0.
- flush_i  input  1  kill all held instructions (branch/jump redirect).
- level_o  output  2  occupancy, 0..2 (0..1 when SKID=0).

Behaviour:
Definitions:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.

Reset (rst_n=0 at posedge, synchronous, highest priority):
- out_valid=0, inst_o=NOP_INST, pc_o=0, level_o=0.
- Skid entry invalid; in_ready=1 from the first cycle after reset.
- No fire is honoured in the reset cycle.
- Reset mid-operation discards all entries.

Flush (flush_i=1, rst_n=1):
- Next state is EMPTY; out_valid=0, inst_o=NOP_INST, level_o=0.
- pc_o holds its previous value.
- Any in_fire in the same cycle is discarded; flush wins over simultaneous in_fire and out_fire.
- in_ready=1 on the following cycle.

SKID=1 states: EMPTY(0), ONE(1), FULL(2); level_o reflects the current state.
- in_ready = 1 in EMPTY/ONE, 0 in FULL. It is a registered flop with no combinational path from out_ready.
- EMPTY:
  - in_fire -> ONE; head <= {pc_i, inst_i}.
  - otherwise stay EMPTY.
- ONE:
  - in_fire & out_fire -> ONE; head <= input.
  - in_fire & !out_ready -> FULL; skid <= input, head unchanged.
  - !in_fire & out_fire -> EMPTY; inst_o <= NOP_INST, pc_o held.
  - otherwise hold.
- FULL:
  - out_fire -> ONE; head <= skid.
  - otherwise hold.
  - No in_fire is possible.

SKID=0:
- in_ready = !out_valid | out_ready (combinational), forced 0 during the reset cycle.
- in_fire loads head and sets out_valid=1.
- out_fire without in_fire clears out_valid and sets inst_o=NOP_INST.
- level_o = {1'b0, out_valid}.

Ordering and latency:
- Instructions leave in acceptance order (FIFO); no drop or duplication except on flush or reset.
- Latency from in_fire to out_valid is 1 cycle when the stage is empty.
- Throughput is 1 instruction per cycle while out_ready=1.

General rules:
- pc_o/inst_o are stable while out_valid=1 and out_ready=0.
- Inputs are ignored when in_ready=0; no widening or truncation of data.

Test Plan:
- Reset with in_valid=1, inst_i=32'hDEADBEEF: during the rst_n=0 cycle nothing is captured. Then:
  - inst_o=32'h00000013, pc_o=0, out_valid=0, level_o=0, in_ready=1.
  - Outputs are unchanged on the cycle after reset releases.
- Streaming, out_ready=1, PC 0x0,0x4,0x8 with inst A,B,C on consecutive cycles -> out_valid=1 one cycle later and A,B,C appear at pc_o 0x0,0x4,0x8 on consecutive cycles.
- Backpressure (SKID=1): out_ready=0 while offering 0x0/A then 0x4/B:
  - level_o goes 1 then 2; in_ready=0 in FULL; offer 0x8/C is held off.
  - Raising out_ready drains A, then B, then C in order, with no loss.
- Flush in FULL with a simultaneous in_valid=1 (0x10/D) -> next cycle out_valid=0, level_o=0, inst_o=NOP, in_ready=1; D is never output.
- SKID=0 with out_ready=0 and out_valid=1 -> in_ready=0 combinationally. When out_ready rises, in_ready=1 in the same cycle and a new instruction replaces the head (level_o stays 1).
- rst_n=0 asserted in FULL mid-stream -> all entries dropped; the post-reset state matches the first scenario.
